// File: rtl/score_pkg.sv
// score_pkg: shared constants for the score keeper slice.
//   - game phase encoding (ST_IDLE / ST_PLAY / ST_OVER)
//   - award source indices and count
//   - src_idx(): modular source index used by the round-robin search
package score_pkg;

  localparam int unsigned NUM_SRC   = 3;
  localparam int unsigned SRC_COIN  = 0;
  localparam int unsigned SRC_STOMP = 1;
  localparam int unsigned SRC_FLAG  = 2;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_PLAY = 2'd1;
  localparam state_t ST_OVER = 2'd2;

  // (base + off) mod NUM_SRC
  function automatic logic [1:0] src_idx(input logic [1:0] base, input int unsigned off);
    int unsigned s;
    s = 32'(base) + off;
    return 2'(s % NUM_SRC);
  endfunction

endpackage

// File: rtl/score_if.sv
// score_if: game control, award handshake and display signals of the score keeper.
//   master: game logic / requesters (drives pulses and reqs, receives acks and display state)
//   slave : score_keeper
interface score_if;

  logic       game_start;
  logic       game_over;
  logic       coin_req;
  logic       stomp_req;
  logic       flag_req;
  logic       coin_ack;
  logic       stomp_ack;
  logic       flag_ack;
  logic [6:0] score;
  logic [6:0] high_score;
  logic       blank;
  logic       playing;

  modport master (
    output game_start, game_over, coin_req, stomp_req, flag_req,
    input  coin_ack, stomp_ack, flag_ack, score, high_score, blank, playing
  );

  modport slave (
    input  game_start, game_over, coin_req, stomp_req, flag_req,
    output coin_ack, stomp_ack, flag_ack, score, high_score, blank, playing
  );

endinterface

// File: rtl/score_rr_arbiter.sv
// score_rr_arbiter: 3-way round-robin arbiter.
//   clk, reset : clock, synchronous active-high reset
//   en_i       : grants allowed this cycle
//   req_i      : pending requests
//   excl_i     : sources masked this cycle (their ack is currently high)
//   gnt_o      : one-hot grant (all zero when nothing eligible or disabled)
// The search starts at the pointer; the pointer moves past the winner.
module score_rr_arbiter
  import score_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               en_i,
  input  logic [NUM_SRC-1:0] req_i,
  input  logic [NUM_SRC-1:0] excl_i,
  output logic [NUM_SRC-1:0] gnt_o
);

  logic [1:0]         ptr_q, ptr_d;
  logic [NUM_SRC-1:0] elig;
  logic               found;
  logic [1:0]         idx;

  always_comb begin
    elig  = req_i & ~excl_i;
    gnt_o = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    idx   = '0;
    if (en_i) begin
      for (int unsigned k = 0; k < NUM_SRC; k++) begin
        idx = src_idx(ptr_q, k);
        if (!found && elig[idx]) begin
          found      = 1'b1;
          gnt_o[idx] = 1'b1;
          ptr_d      = src_idx(idx, 1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/score_keeper.sv
// score_keeper: game phase FSM, saturating score accumulator, high-score register
// and post-record blink control.
//   clk, reset : clock, synchronous active-high reset
//   sif        : score_if.slave (game_start/game_over pulses, coin/stomp/flag req/ack,
//                score, high_score, blank, playing)
module score_keeper
  import score_pkg::*;
#(
  parameter int unsigned MAX_SCORE    = 99,
  parameter int unsigned COIN_PTS     = 1,
  parameter int unsigned STOMP_PTS    = 2,
  parameter int unsigned FLAG_PTS     = 10,
  parameter int unsigned BLINK_CYCLES = 25_000_000
) (
  input logic    clk,
  input logic    reset,
  score_if.slave sif
);

  localparam int unsigned CntW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(BLINK_CYCLES - 1);

  state_t             state_q, state_d;
  logic [6:0]         score_q, score_d;
  logic [6:0]         high_q, high_d;
  logic               new_rec_q, new_rec_d;
  logic               blank_q, blank_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [NUM_SRC-1:0] ack_q;
  logic [NUM_SRC-1:0] req;
  logic [NUM_SRC-1:0] gnt;
  logic               arb_en;
  logic [6:0]         pts;
  logic [7:0]         sum;
  logic [6:0]         sat;

  assign req[SRC_COIN]  = sif.coin_req;
  assign req[SRC_STOMP] = sif.stomp_req;
  assign req[SRC_FLAG]  = sif.flag_req;

  // game_over pre-empts any grant in the cycle it arrives
  assign arb_en = (state_q == ST_PLAY) && !sif.game_over;

  score_rr_arbiter u_arb (
    .clk    (clk),
    .reset  (reset),
    .en_i   (arb_en),
    .req_i  (req),
    .excl_i (ack_q),
    .gnt_o  (gnt)
  );

  always_comb begin
    pts = '0;
    if (gnt[SRC_COIN])  pts = 7'(COIN_PTS);
    if (gnt[SRC_STOMP]) pts = 7'(STOMP_PTS);
    if (gnt[SRC_FLAG])  pts = 7'(FLAG_PTS);
    sum = {1'b0, score_q} + {1'b0, pts};
    sat = (sum > 8'(MAX_SCORE)) ? 7'(MAX_SCORE) : sum[6:0];
  end

  always_comb begin
    state_d   = state_q;
    score_d   = score_q;
    high_d    = high_q;
    new_rec_d = new_rec_q;
    blank_d   = blank_q;
    cnt_d     = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (sif.game_start) begin
          state_d = ST_PLAY;
          score_d = '0;
        end
      end
      ST_PLAY: begin
        if (sif.game_over) begin
          state_d = ST_OVER;
          blank_d = 1'b0;
          cnt_d   = '0;
          if (score_q > high_q) begin
            high_d    = score_q;
            new_rec_d = 1'b1;
          end else begin
            new_rec_d = 1'b0;
          end
        end else if (|gnt) begin
          score_d = sat;
        end
      end
      ST_OVER: begin
        if (sif.game_start) begin
          state_d   = ST_PLAY;
          score_d   = '0;
          blank_d   = 1'b0;
          cnt_d     = '0;
          new_rec_d = 1'b0;
        end else if (new_rec_q) begin
          if (cnt_q == CntLast) begin
            cnt_d   = '0;
            blank_d = ~blank_q;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      score_q   <= '0;
      high_q    <= '0;
      new_rec_q <= 1'b0;
      blank_q   <= 1'b0;
      cnt_q     <= '0;
      ack_q     <= '0;
    end else begin
      state_q   <= state_d;
      score_q   <= score_d;
      high_q    <= high_d;
      new_rec_q <= new_rec_d;
      blank_q   <= blank_d;
      cnt_q     <= cnt_d;
      ack_q     <= gnt;
    end
  end

  assign sif.coin_ack   = ack_q[SRC_COIN];
  assign sif.stomp_ack  = ack_q[SRC_STOMP];
  assign sif.flag_ack   = ack_q[SRC_FLAG];
  assign sif.score      = score_q;
  assign sif.high_score = high_q;
  assign sif.blank      = blank_q;
  assign sif.playing    = (state_q == ST_PLAY);

endmodule

// File: doc/score_keeper.md
# score_keeper

Sequential score controller for the Mario game datapath. It arbitrates point-award requests from the coin, stomp and flag logic and accumulates them into a saturating 7-bit score, which feeds the two-digit 7-segment score decoder. It also sequences the game phase (idle / play / over), keeps a high-score register, and drives a blink/blank control so the display flashes after a new record.

## Interface
Parameters:
- MAX_SCORE, 99, saturation ceiling; must be ≤ 99 so the two-digit display never overflows.
- COIN_PTS, 1, points per coin grant.
- STOMP_PTS, 2, points per stomp grant.
- FLAG_PTS, 10, points per flag grant.
- BLINK_CYCLES, 25_000_000, length of each blink half-period in clk cycles; must be ≥ 1.

Ports:
- clk  input  1  system clock; one clock domain.
- reset  input  1  synchronous, active-high reset.
- game_start  input  1  one-cycle pulse that starts a game.
- game_over  input  1  one-cycle pulse that ends a game.
- coin_req / stomp_req / flag_req  input  1 each  award requests; each is held high until its ack.
- coin_ack / stomp_ack / flag_ack  output  1 each  one-cycle grant pulse.
- score  output  7  current score, 0..MAX_SCORE.
- high_score  output  7  best score since reset.
- blank  output  1  when high, the score display is blanked.
- playing  output  1  high in ST_PLAY.

## Operation
- States: ST_IDLE, ST_PLAY, ST_OVER. Reset → ST_IDLE.
- ST_IDLE: game_start → ST_PLAY, score←0. No grants are issued.
- ST_PLAY:
  - Round-robin arbiter over {coin=0, stomp=1, flag=2}. Search starts at rr_ptr. A source whose ack is high this cycle is excluded.
  - On a grant to source i: ack_i←1 for one cycle, score←min(score+PTS_i, MAX_SCORE), rr_ptr←(i+1) mod 3.
  - At most one grant per cycle.
- ST_PLAY + game_over → ST_OVER.
  - game_over has priority: no grant is issued that cycle.
  - If score > high_score: high_score←score and new_record←1; otherwise new_record←0.
  - game_over and game_start in the same cycle: game_over wins.
- ST_OVER:
  - If new_record: blank toggles every BLINK_CYCLES cycles, starting with blank=0 and the blink counter at 0 on entry.
  - Otherwise blank=0.
  - Requests stay pending and are not acked.
  - game_start → ST_PLAY, score←0, blank←0, counter←0.
- game_start in ST_PLAY is ignored. game_over outside ST_PLAY is ignored.
- Arithmetic: sum is computed 8 bits wide, then clamped; the registered score never exceeds MAX_SCORE.
- Requester rule: drop req the cycle after ack. A req still high after the ack cycle is treated as a new request.

## Timing
- Reset values: score=0, high_score=0, blank=0, playing=0, all acks=0, rr_ptr=0, new_record=0, blink counter=0, state=ST_IDLE.
- Reset applies on the next clk edge regardless of state. A pending req is dropped without ack, and any in-flight blink stops.
- Grant latency: req sampled high at edge N → ack and updated score visible after edge N+1. Single-cycle throughput across different sources.
- Same-source back-to-back requests: at most one grant every 2 cycles, because of the ack exclusion.
- game_start / game_over: state, score and high_score update one edge after the pulse is sampled. playing follows the registered state.
- Blink: first toggle to blank=1 occurs BLINK_CYCLES cycles after entry to ST_OVER.

## Structure
- Package score_pkg holds:
  - the state enum {ST_IDLE, ST_PLAY, ST_OVER};
  - source index constants SRC_COIN=0, SRC_STOMP=1, SRC_FLAG=2;
  - the NUM_SRC=3 constant.
- One sub-module, score_rr_arbiter: 3-way round-robin with pointer register, req/exclude inputs, one-hot grant output, and an enable driven by (state==ST_PLAY && !game_over).
- Saturation, the FSM, the high-score register and the blink counter live in score_keeper.

## Test plan
- Reset, then start, then coin_req held: ack after 1 edge, score 0→1; req dropped → no further ack.
- All three reqs held continuously from rr_ptr=0: grants in order coin, stomp, flag, coin… → score 1, 3, 13, 14.
- Score 95, flag request: score clamps to 99; a further coin grant leaves it at 99 and ack still pulses.
- game_over in the same cycle as coin_req: no ack. State goes to ST_OVER; score 40 > high_score 0 → high_score=40. With BLINK_CYCLES=4, blank toggles 0→1→0 every 4 cycles.
- Second game ends at score 20 (< 40): high_score stays 40 and blank stays 0. game_start → score 0, playing=1, and the pending req is then acked.
- Reset asserted mid-blink while stomp_req is pending: all outputs return to reset values next edge, and no ack is issued.
